regfile_wb_arbiter: RTL

// - Shares the single write port of the 32x32 register file between two writeback

---
 rtl/regfile_wb_arbiter_if.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback port bundle for regfile_wb_arbiter.
// Groups the two requester handshakes, hold, the register-file write port,
// the decode hazard query and the conflict counter.
// The requester side drives through the master modport.
// The arbiter connects through the slave modport.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] q_addr;
  logic              q_busy;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold, q_addr,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, q_busy, conflict_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold, q_addr,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, q_busy, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Requester A is the ALU result and requester B is the load result.
// An accepted request is written to the register file one cycle later, through a registered write stage.
//
// Optional feature: ZERO_REG_PROTECT_EN.
// When it is defined, an accepted write to r0 completes its handshake but is never issued.
//
// rr_ptr state | meaning
// RR_A         | A wins the next contention cycle
// RR_B         | B wins the next contention cycle
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

  rr_e               rr_ptr_q, rr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic              grant_a, grant_b, accept, wr_issue, contend;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  // Grant decision. Ready is gated by reset so that nothing is accepted while in reset.
  always_comb begin
    contend  = bus.a_valid && bus.b_valid && !bus.hold;
    grant_a  = rst_n && !bus.hold && bus.a_valid && (!bus.b_valid || rr_ptr_q == RR_A);
    grant_b  = rst_n && !bus.hold && bus.b_valid && (!bus.a_valid || rr_ptr_q == RR_B);
    accept   = grant_a || grant_b;
    acc_addr = grant_b ? bus.b_addr : bus.a_addr;
    acc_data = grant_b ? bus.b_data : bus.a_data;
`ifdef ZERO_REG_PROTECT_EN
    wr_issue = accept && (acc_addr != '0);
`else
    wr_issue = accept;
`endif
  end

  // Next state: the pointer moves to the loser, the write stage captures only issued writes,
  // and the counter saturates.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    wr_en_d        = wr_issue;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    conflict_cnt_d = conflict_cnt_q;
    if (grant_a) begin
      rr_ptr_d = RR_B;
    end else if (grant_b) begin
      rr_ptr_d = RR_A;
    end
    if (wr_issue) begin
      wr_addr_d = acc_addr;
      wr_data_d = acc_data;
    end
    if (contend && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  // All arbiter state, cleared asynchronously so an in-flight write is dropped at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= RR_A;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Outputs. q_busy looks only at the registered write stage, never at the requesters.
  always_comb begin
    bus.a_ready      = grant_a;
    bus.b_ready      = grant_b;
    bus.wr_en        = wr_en_q;
    bus.wr_addr      = wr_addr_q;
    bus.wr_data      = wr_data_q;
    bus.conflict_cnt = conflict_cnt_q;
`ifdef ZERO_REG_PROTECT_EN
    bus.q_busy       = wr_en_q && (wr_addr_q == bus.q_addr) && (bus.q_addr != '0);
`else
    bus.q_busy       = wr_en_q && (wr_addr_q == bus.q_addr);
`endif
  end

endmodule
